// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID buffer: registered head toward decode, registered in_ready toward fetch.
// Define IF_ID_PERF_EN to add the full/flush-drop/stall performance counters.
module if_id_buffer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013),
    parameter int              PERF_W   = 32
) (
    input  logic            clock,
    input  logic            reset,
`ifdef IF_ID_PERF_EN
    output logic [PERF_W-1:0] perf_full_cycles,
    output logic [PERF_W-1:0] perf_flush_drops,
    output logic [PERF_W-1:0] perf_stall_cycles,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_snpc,
    input  logic [XLEN-1:0] in_inst,
    input  logic            flush,
    input  logic            stall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_snpc,
    output logic [XLEN-1:0] out_inst
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] snpc;
        logic [XLEN-1:0] inst;
    } beat_t;

    beat_t      mem_q [2];
    beat_t      in_beat;
    beat_t      head_src;
    beat_t      head_q, head_d;

    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;

    logic       push;
    logic       pop;

    assign in_beat = '{pc: in_pc, snpc: in_snpc, inst: in_inst};

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);

    // flush dominates both events so nothing moves in a redirect cycle
    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = out_valid & out_ready & ~stall & ~flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        in_ready_d = (count_d != 2'd2);
    end

    // The next head is the beat being written this cycle when it lands at the
    // new read pointer; this gives the zero-bubble path from an empty buffer.
    always_comb begin
        head_src = (push && (wr_ptr_q == rd_ptr_d)) ? in_beat : mem_q[rd_ptr_d];
        head_d   = head_q;
        if (count_d == 2'd0) begin
            head_d.inst = NOP_INST;
        end else begin
            head_d = head_src;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before this edge, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            in_ready_q <= 1'b1;
            head_q     <= '{pc: '0, snpc: '0, inst: NOP_INST};
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
        end
    end

    // NOTE: the storage array is not reset; count and the pointers alone decide
    // which entries are live, so stale contents are never presented.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_beat;
        end
    end

    assign out_pc   = head_q.pc;
    assign out_snpc = head_q.snpc;
    assign out_inst = head_q.inst;

`ifdef IF_ID_PERF_EN
    logic [PERF_W-1:0] perf_full_q;
    logic [PERF_W-1:0] perf_drop_q;
    logic [PERF_W-1:0] perf_stall_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_full_q  <= '0;
            perf_drop_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (count_q == 2'd2) begin
                perf_full_q <= perf_full_q + PERF_W'(1);
            end
            // live entries plus the beat fetch offered in the redirect cycle
            if (flush) begin
                perf_drop_q <= perf_drop_q + PERF_W'(count_q) + PERF_W'(in_valid);
            end
            if (stall && out_valid) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_flush_drops  = perf_drop_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_if_id_buffer;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_snpc = '0;
    logic [XLEN-1:0] in_inst = '0;
    logic            flush = 1'b0;
    logic            stall = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_snpc;
    logic [XLEN-1:0] out_inst;
`ifdef IF_ID_PERF_EN
    logic [31:0]     perf_full_cycles;
    logic [31:0]     perf_flush_drops;
    logic [31:0]     perf_stall_cycles;
`endif

    if_id_buffer dut (
        .clock     (clock),
        .reset     (reset),
`ifdef IF_ID_PERF_EN
        .perf_full_cycles (perf_full_cycles),
        .perf_flush_drops (perf_flush_drops),
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_snpc   (in_snpc),
        .in_inst   (in_inst),
        .flush     (flush),
        .stall     (stall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_snpc  (out_snpc),
        .out_inst  (out_inst)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] snpc;
        logic [31:0] inst;
    } beat_t;

    beat_t       q[$];
    bit          rdy_m;
    logic [31:0] last_pc, last_snpc;
    logic [31:0] m_full, m_drops, m_stall;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rdy_m     = 1'b1;
        last_pc   = '0;
        last_snpc = '0;
        m_full    = '0;
        m_drops   = '0;
        m_stall   = '0;
    endtask

    task automatic check_outputs(input string tag);
        bit ne;
        ne = (q.size() != 0);
        check({tag, ".out_valid"}, out_valid, ne);
        check({tag, ".in_ready"}, in_ready, rdy_m);
        check({tag, ".out_pc"}, out_pc, ne ? q[0].pc : last_pc);
        check({tag, ".out_snpc"}, out_snpc, ne ? q[0].snpc : last_snpc);
        check({tag, ".out_inst"}, out_inst, ne ? q[0].inst : NOP);
`ifdef IF_ID_PERF_EN
        check({tag, ".perf_full"}, perf_full_cycles, m_full);
        check({tag, ".perf_drops"}, perf_flush_drops, m_drops);
        check({tag, ".perf_stall"}, perf_stall_cycles, m_stall);
`endif
    endtask

    // Called at a falling edge: drive inputs, advance one clock, update the model, check.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                        input bit fl, input bit st, input bit ordy, output bit accepted);
        bit push, pop;
        in_valid  = v;
        in_pc     = pc;
        in_snpc   = pc + 32'd4;
        in_inst   = inst;
        flush     = fl;
        stall     = st;
        out_ready = ordy;
        push = v && rdy_m && !fl;
        pop  = (q.size() != 0) && ordy && !st && !fl;
        @(posedge clock);
        if (q.size() == 2) m_full = m_full + 32'd1;
        if (fl) m_drops = m_drops + q.size() + (v ? 32'd1 : 32'd0);
        if (st && q.size() != 0) m_stall = m_stall + 32'd1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{pc, pc + 32'd4, inst});
        end
        rdy_m = (q.size() < 2);
        if (q.size() != 0) begin
            last_pc   = q[0].pc;
            last_snpc = q[0].snpc;
        end
        accepted = push;
        @(negedge clock);
        check_outputs("step");
    endtask

    // Fetch holds the beat until the buffer takes it; bounded retry.
    task automatic send(input logic [31:0] pc, input bit ordy);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 16 && !acc; i++) begin
            step(1'b1, pc, pc ^ 32'hA5A5_0000, 1'b0, 1'b0, ordy, acc);
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: pc %0h never accepted", pc);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ordy, acc);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_outputs("reset");
    endtask

    initial begin
        bit          acc, have, fl, st, ordy;
        logic [31:0] pc_r, cur_pc, cur_inst;

        model_reset();
        #12;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.out_pc", out_pc, 32'h0);
        check("rst.out_snpc", out_snpc, 32'h0);
        check("rst.out_inst", out_inst, NOP);
        do_reset();

        // streaming with no bubbles
        step(1'b1, 32'h0, 32'h1111, 1'b0, 1'b0, 1'b1, acc);
        check("stream.pc0", out_pc, 32'h0);
        step(1'b1, 32'h4, 32'h2222, 1'b0, 1'b0, 1'b1, acc);
        check("stream.pc4", out_pc, 32'h4);
        step(1'b1, 32'h8, 32'h3333, 1'b0, 1'b0, 1'b1, acc);
        check("stream.pc8", out_pc, 32'h8);
        check("stream.ready", in_ready, 1'b1);
        idle(2, 1'b1);

        // back-pressure
        step(1'b1, 32'h10, 32'h10, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h14, 32'h14, 1'b0, 1'b0, 1'b0, acc);
        check("bp.full_ready", in_ready, 1'b0);
        step(1'b1, 32'h18, 32'h18, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h18, 32'h18, 1'b0, 1'b0, 1'b0, acc);
        check("bp.head_held", out_pc, 32'h10);
        send(32'h18, 1'b1);
        idle(3, 1'b1);

        // flush with two entries and an offered beat
        step(1'b1, 32'h20, 32'h20, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h24, 32'h24, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h28, 32'h28, 1'b1, 1'b0, 1'b0, acc);
        check("flush.valid", out_valid, 1'b0);
        check("flush.inst", out_inst, NOP);
        check("flush.ready", in_ready, 1'b1);
        step(1'b1, 32'h100, 32'h100, 1'b0, 1'b0, 1'b1, acc);
        check("flush.target", out_pc, 32'h100);
        idle(2, 1'b1);

        // stall holds the head while pushes continue
        step(1'b1, 32'h40, 32'h40, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 32'h44, 32'h44, 1'b0, 1'b1, 1'b1, acc);
        check("stall.pc_a", out_pc, 32'h40);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, acc);
        check("stall.pc_b", out_pc, 32'h40);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        check("stall.popped", out_pc, 32'h44);
        idle(2, 1'b1);

        // asynchronous reset in the middle of a cycle while full
        step(1'b1, 32'h50, 32'h50, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h54, 32'h54, 1'b0, 1'b0, 1'b0, acc);
        #2;
        reset = 1'b0;
        #1;
        check("async.valid", out_valid, 1'b0);
        check("async.inst", out_inst, NOP);
        check("async.ready", in_ready, 1'b1);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        idle(1, 1'b1);

`ifdef IF_ID_PERF_EN
        do_reset();
        step(1'b1, 32'h60, 32'h60, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h64, 32'h64, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h68, 32'h68, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h68, 32'h68, 1'b1, 1'b0, 1'b0, acc);
        check("perf.full5", perf_full_cycles, 32'd5);
        check("perf.drops3", perf_flush_drops, 32'd3);
`endif

        // randomized traffic against the queue model
        do_reset();
        have     = 1'b0;
        pc_r     = 32'h1000;
        cur_pc   = '0;
        cur_inst = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!have && $urandom_range(3) != 0) begin
                have     = 1'b1;
                cur_pc   = pc_r;
                cur_inst = $urandom;
            end
            fl   = ($urandom_range(19) == 0);
            st   = ($urandom_range(4) == 0);
            ordy = ($urandom_range(3) != 0);
            step(have, cur_pc, cur_inst, fl, st, ordy, acc);
            if (acc || (fl && have)) begin
                have = 1'b0;
                pc_r = pc_r + 32'd4;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
